// File: rtl/uart_line_packer_pkg.sv
// Shared definitions for the UART line packer: byte/pixel widths, default sync
// header bytes, packet framing overhead, FSM state encoding and small helpers.
package uart_line_packer_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned LINE_W = 16;

    // Default two-byte sync header; the host re-synchronises on this pattern.
    localparam logic [BYTE_W-1:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [BYTE_W-1:0] SYNC1_DEFAULT = 8'h5A;

    // Non-pixel bytes per packet: two sync, two line number, one checksum.
    localparam int unsigned PACKET_OVERHEAD = 5;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SYNC0    = 4'd1,
        ST_SYNC1    = 4'd2,
        ST_LINE_HI  = 4'd3,
        ST_LINE_LO  = 4'd4,
        ST_PIX_WAIT = 4'd5,
        ST_PIX_HI   = 4'd6,
        ST_PIX_LO   = 4'd7,
        ST_CSUM     = 4'd8
    } state_e;

    // Pixel counter width; a one-pixel line still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned line_length);
        return (line_length > 1) ? $clog2(line_length) : 1;
    endfunction

    // States that present a byte to the transmitter.
    function automatic logic emits_byte(input state_e s);
        case (s)
            ST_SYNC0, ST_SYNC1, ST_LINE_HI, ST_LINE_LO,
            ST_PIX_HI, ST_PIX_LO, ST_CSUM: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // States whose accepted byte is folded into the checksum (sync excluded).
    function automatic logic in_checksum(input state_e s);
        case (s)
            ST_LINE_HI, ST_LINE_LO, ST_PIX_HI, ST_PIX_LO: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_line_packer.sv
// UART line packer: serialises one video line of 16-bit pixels into a framed
// byte packet  Sync0 Sync1 line[15:8] line[7:0] {pix[15:8] pix[7:0]}*N csum
// where csum is the XOR of every byte from line[15:8] through the last pixel.
//
// Ports:
//   CLK, RST        clock; synchronous active-low reset
//   i_start         start a packet (sampled only while idle)
//   i_line          line number, latched with i_start
//   i_pix_valid/i_pix, o_pix_ready   pixel handshake (ready only in PIX_WAIT)
//   o_byte/o_byte_valid, i_byte_ready byte handshake toward the transmitter
//   o_busy          packet in progress
//   o_line_done     one-cycle pulse after the checksum byte is accepted
module uart_line_packer
    import uart_line_packer_pkg::*;
#(
    parameter int unsigned        LineLength = 640,
    parameter logic [BYTE_W-1:0]  Sync0      = SYNC0_DEFAULT,
    parameter logic [BYTE_W-1:0]  Sync1      = SYNC1_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_start,
    input  logic [LINE_W-1:0] i_line,
    input  logic              i_pix_valid,
    input  logic [PIX_W-1:0]  i_pix,
    output logic              o_pix_ready,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_byte_valid,
    input  logic              i_byte_ready,
    output logic              o_busy,
    output logic              o_line_done
);

    localparam int unsigned   CntW    = cnt_width(LineLength);
    localparam logic [CntW-1:0] CntLast = CntW'(LineLength - 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [PIX_W-1:0]    pix_q, pix_d;

    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic                byte_valid_q, byte_valid_d;
    logic                pix_ready_q, pix_ready_d;
    logic                busy_q, busy_d;
    logic                line_done_q, line_done_d;

    // Handshake qualifiers; both are built from registered outputs only.
    logic byte_acc;
    logic pix_acc;
    logic last_pix;

    assign byte_acc = byte_valid_q & i_byte_ready;
    assign pix_acc  = pix_ready_q & i_pix_valid;
    assign last_pix = (cnt_q == CntLast);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every emitting state advances only on a byte accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (i_start)  state_d = ST_SYNC0;
            ST_SYNC0:    if (byte_acc) state_d = ST_SYNC1;
            ST_SYNC1:    if (byte_acc) state_d = ST_LINE_HI;
            ST_LINE_HI:  if (byte_acc) state_d = ST_LINE_LO;
            ST_LINE_LO:  if (byte_acc) state_d = ST_PIX_WAIT;
            ST_PIX_WAIT: if (pix_acc)  state_d = ST_PIX_HI;
            ST_PIX_HI:   if (byte_acc) state_d = ST_PIX_LO;
            ST_PIX_LO: begin
                if (byte_acc) begin
                    state_d = last_pix ? ST_CSUM : ST_PIX_WAIT;
                end
            end
            ST_CSUM:     if (byte_acc) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: line/pixel latches, pixel counter and checksum.
    always_comb begin
        line_d = line_q;
        pix_d  = pix_q;
        cnt_d  = cnt_q;
        csum_d = csum_q;

        if ((state_q == ST_IDLE) && i_start) begin
            line_d = i_line;
            cnt_d  = '0;
            csum_d = '0;
        end

        if (pix_acc) begin
            pix_d = i_pix;
        end

        // byte_q is exactly the byte being accepted this cycle.
        if (byte_acc && in_checksum(state_q)) begin
            csum_d = csum_q ^ byte_q;
        end

        // Counter clears explicitly on the last pixel; it never wraps on its own.
        if ((state_q == ST_PIX_LO) && byte_acc) begin
            cnt_d = last_pix ? '0 : cnt_q + CntW'(1);
        end
    end

    // Output logic, evaluated on the next state so that every output is a
    // flop that lines up with state_q. A stalled state keeps line/pix/csum
    // unchanged, so the presented byte holds stable until accepted.
    always_comb begin
        byte_d       = '0;
        byte_valid_d = emits_byte(state_d);
        pix_ready_d  = (state_d == ST_PIX_WAIT);
        busy_d       = (state_d != ST_IDLE);
        line_done_d  = (state_q == ST_CSUM) && byte_acc;

        case (state_d)
            ST_SYNC0:   byte_d = Sync0;
            ST_SYNC1:   byte_d = Sync1;
            ST_LINE_HI: byte_d = line_d[15:8];
            ST_LINE_LO: byte_d = line_d[7:0];
            ST_PIX_HI:  byte_d = pix_d[15:8];
            ST_PIX_LO:  byte_d = pix_d[7:0];
            ST_CSUM:    byte_d = csum_d;
            default:    byte_d = '0;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_q        <= '0;
            csum_q       <= '0;
            line_q       <= '0;
            pix_q        <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            pix_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            line_done_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            csum_q       <= csum_d;
            line_q       <= line_d;
            pix_q        <= pix_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            pix_ready_q  <= pix_ready_d;
            busy_q       <= busy_d;
            line_done_q  <= line_done_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_pix_ready  = pix_ready_q;
    assign o_busy       = busy_q;
    assign o_line_done  = line_done_q;

endmodule

// File: tb/tb_uart_line_packer.sv
// Bench for uart_line_packer: a two-pixel-line instance driven through a
// scoreboard of expected bytes, plus a full 640-pixel line streamed into a
// four-entry transmitter FIFO model that drains slower than the packer.
module tb_uart_line_packer;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    logic        CLK;
    logic        RST;

    // Short-line instance (LineLength = 2).
    logic        i_start;
    logic [15:0] i_line;
    logic        i_pix_valid;
    logic [15:0] i_pix;
    logic        o_pix_ready;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        i_byte_ready;
    logic        o_busy;
    logic        o_line_done;

    // Full-line instance (LineLength = 640).
    logic        s_start;
    logic [15:0] s_line;
    logic        s_pix_valid;
    logic [15:0] s_pix;
    logic        s_pix_ready;
    logic [7:0]  s_byte;
    logic        s_byte_valid;
    logic        s_byte_ready;
    logic        s_busy;
    logic        s_line_done;

    int          total;
    int          bad;

    exp_t        exp_q[$];
    logic [15:0] pixq[$];
    logic        pix_hold;
    logic        rand_bp;
    logic        done_exp;
    logic        hold_pend;
    logic [7:0]  hold_byte;
    logic        pxfer;

    uart_line_packer #(.LineLength(2)) dut (
        .CLK(CLK), .RST(RST),
        .i_start(i_start), .i_line(i_line),
        .i_pix_valid(i_pix_valid), .i_pix(i_pix), .o_pix_ready(o_pix_ready),
        .o_byte(o_byte), .o_byte_valid(o_byte_valid), .i_byte_ready(i_byte_ready),
        .o_busy(o_busy), .o_line_done(o_line_done)
    );

    uart_line_packer #(.LineLength(640)) dut_long (
        .CLK(CLK), .RST(RST),
        .i_start(s_start), .i_line(s_line),
        .i_pix_valid(s_pix_valid), .i_pix(s_pix), .o_pix_ready(s_pix_ready),
        .o_byte(s_byte), .o_byte_valid(s_byte_valid), .i_byte_ready(s_byte_ready),
        .o_busy(s_busy), .o_line_done(s_line_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One clock: scoreboard check at negedge, then pixel source and optional
    // random backpressure update just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        pxfer = 1'b0;
        if (RST !== 1'b1) begin
            hold_pend = 1'b0;
            done_exp  = 1'b0;
        end else begin
            if (o_line_done === 1'b1 || done_exp) begin
                total++;
                if (o_line_done !== done_exp) begin
                    bad++;
                    $display("FAIL line_done: got %b want %b", o_line_done, done_exp);
                end
            end
            done_exp = 1'b0;
            if (hold_pend) begin
                total++;
                if (o_byte_valid !== 1'b1 || o_byte !== hold_byte) begin
                    bad++;
                    $display("FAIL hold_stable: got valid=%b byte=%h want valid=1 byte=%h",
                             o_byte_valid, o_byte, hold_byte);
                end
            end
            hold_pend = 1'b0;
            if (o_byte_valid === 1'b1 && i_byte_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_byte: got %h want no byte", o_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (o_byte !== e.b) begin
                        bad++;
                        $display("FAIL byte: got %h want %h", o_byte, e.b);
                    end
                    done_exp = e.last;
                end
            end else if (o_byte_valid === 1'b1) begin
                hold_pend = 1'b1;
                hold_byte = o_byte;
            end
            pxfer = (o_pix_ready === 1'b1) && i_pix_valid;
        end
        @(posedge CLK);
        #1;
        if (pxfer && pixq.size() > 0) void'(pixq.pop_front());
        if (!pix_hold && pixq.size() > 0) begin
            i_pix_valid = 1'b1;
            i_pix       = pixq[0];
        end else begin
            i_pix_valid = 1'b0;
        end
        if (rand_bp) i_byte_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic push_exp(input logic [7:0] b, input logic last);
        exp_t e;
        e.b    = b;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Queue a two-pixel packet's expected bytes and pixels, then pulse i_start.
    task automatic start_packet(input logic [15:0] line, input logic [15:0] p0,
                                input logic [15:0] p1);
        logic [7:0] cs;
        cs = line[15:8] ^ line[7:0] ^ p0[15:8] ^ p0[7:0] ^ p1[15:8] ^ p1[7:0];
        push_exp(8'hA5, 1'b0);
        push_exp(8'h5A, 1'b0);
        push_exp(line[15:8], 1'b0);
        push_exp(line[7:0], 1'b0);
        push_exp(p0[15:8], 1'b0);
        push_exp(p0[7:0], 1'b0);
        push_exp(p1[15:8], 1'b0);
        push_exp(p1[7:0], 1'b0);
        push_exp(cs, 1'b1);
        pixq.push_back(p0);
        pixq.push_back(p1);
        i_start = 1'b1;
        i_line  = line;
        tick();
        i_start = 1'b0;
    endtask

    // Drain the scoreboard, then check the done pulse cycle and idle return.
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL packet_timeout: got %0d bytes left want 0", exp_q.size());
            exp_q.delete();
            pixq.delete();
        end
        tick();
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_packet: got busy=%b want 0", o_busy);
        end
    endtask

    task automatic wait_pix_ready(input logic lvl);
        int n;
        n = 0;
        while (o_pix_ready !== lvl && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (o_pix_ready !== lvl) begin
            bad++;
            $display("FAIL wait_pix_ready: got %b want %b", o_pix_ready, lvl);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) tick();
        total += 6;
        if (o_byte_valid !== 1'b0) begin bad++; $display("FAIL rst_byte_valid: got %b want 0", o_byte_valid); end
        if (o_pix_ready !== 1'b0)  begin bad++; $display("FAIL rst_pix_ready: got %b want 0", o_pix_ready); end
        if (o_busy !== 1'b0)       begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        if (o_line_done !== 1'b0)  begin bad++; $display("FAIL rst_line_done: got %b want 0", o_line_done); end
        if (o_byte !== 8'h00)      begin bad++; $display("FAIL rst_byte: got %h want 00", o_byte); end
        if (s_busy !== 1'b0)       begin bad++; $display("FAIL rst_long_busy: got %b want 0", s_busy); end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_packet(16'h0123, 16'h1234, 16'hABCD);
        total++;
        if (o_byte_valid !== 1'b1 || o_byte !== 8'hA5 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL first_byte_latency: got valid=%b byte=%h busy=%b want 1 a5 1",
                     o_byte_valid, o_byte, o_busy);
        end
        wait_done(40);
    endtask

    task automatic test_backpressure();
        int n;
        start_packet(16'h0123, 16'h1234, 16'hABCD);
        n = 0;
        while (!(o_byte_valid === 1'b1 && o_byte === 8'h5A) && n < 10) begin
            tick();
            n++;
        end
        i_byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (o_byte_valid !== 1'b1 || o_byte !== 8'h5A) begin
                bad++;
                $display("FAIL stall_sync1 cycle %0d: got valid=%b byte=%h want 1 5a",
                         i, o_byte_valid, o_byte);
            end
            tick();
        end
        i_byte_ready = 1'b1;
        wait_done(40);
    endtask

    task automatic test_pixel_starve();
        pix_hold = 1'b1;
        start_packet(16'h7E81, 16'hF00F, 16'h0FF0);
        wait_pix_ready(1'b1);
        for (int i = 0; i < 10; i++) begin
            total++;
            if (o_byte_valid !== 1'b0 || o_pix_ready !== 1'b1) begin
                bad++;
                $display("FAIL starve cycle %0d: got valid=%b pix_ready=%b want 0 1",
                         i, o_byte_valid, o_pix_ready);
            end
            tick();
        end
        pix_hold = 1'b0;
        wait_done(40);
    endtask

    task automatic test_start_while_busy();
        start_packet(16'h0001, 16'h5555, 16'hAAAA);
        wait_pix_ready(1'b1);
        wait_pix_ready(1'b0);
        i_start = 1'b1;
        i_line  = 16'hBEEF;
        tick();
        i_start = 1'b0;
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_on_ignored_start: got %b want 1", o_busy);
        end
        wait_done(40);
        repeat (3) tick();
        total++;
        if (o_busy !== 1'b0 || o_byte_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_queued_start: got busy=%b valid=%b want 0 0", o_busy, o_byte_valid);
        end
        start_packet(16'h0002, 16'h0000, 16'hFFFF);
        wait_done(40);
    endtask

    task automatic test_reset_mid_line();
        start_packet(16'h4242, 16'h1234, 16'hABCD);
        wait_pix_ready(1'b1);
        wait_pix_ready(1'b0);
        tick();
        total++;
        if (o_byte_valid !== 1'b1 || o_byte !== 8'h34) begin
            bad++;
            $display("FAIL pix_lo_before_reset: got valid=%b byte=%h want 1 34", o_byte_valid, o_byte);
        end
        RST          = 1'b0;
        i_byte_ready = 1'b0;
        tick();
        total++;
        if (o_byte_valid !== 1'b0 || o_busy !== 1'b0 || o_pix_ready !== 1'b0 ||
            o_line_done !== 1'b0 || o_byte !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset: got valid=%b busy=%b pix_ready=%b done=%b byte=%h want 0 0 0 0 00",
                     o_byte_valid, o_busy, o_pix_ready, o_line_done, o_byte);
        end
        exp_q.delete();
        pixq.delete();
        RST          = 1'b1;
        i_byte_ready = 1'b1;
        tick();
        start_packet(16'h0123, 16'h1234, 16'hABCD);
        wait_done(40);
    endtask

    task automatic test_random_backpressure();
        rand_bp = 1'b1;
        for (int p = 0; p < 4; p++) begin
            start_packet(16'($urandom), 16'($urandom), 16'($urandom));
            wait_done(300);
        end
        rand_bp      = 1'b0;
        i_byte_ready = 1'b1;
        tick();
    endtask

    function automatic logic [15:0] pixf(input int k);
        return 16'(k * 40503 + 7);
    endfunction

    // Full 640-pixel line into a depth-4 FIFO model draining one byte per 4 cycles.
    task automatic test_uart_stream();
        logic [7:0] fifo[$];
        logic [7:0] ser[$];
        logic [7:0] expb[$];
        logic [7:0] cs;
        logic [15:0] p;
        logic       acc;
        logic       px;
        logic [7:0] b;
        int         k;
        int         cyc;
        int         dones;

        expb.push_back(8'hA5);
        expb.push_back(8'h5A);
        expb.push_back(8'h01);
        expb.push_back(8'hF3);
        cs = 8'h01 ^ 8'hF3;
        for (int i = 0; i < 640; i++) begin
            p = pixf(i);
            expb.push_back(p[15:8]);
            expb.push_back(p[7:0]);
            cs = cs ^ p[15:8] ^ p[7:0];
        end
        expb.push_back(cs);

        k            = 0;
        cyc          = 0;
        dones        = 0;
        s_line       = 16'h01F3;
        s_pix        = pixf(0);
        s_pix_valid  = 1'b1;
        s_byte_ready = 1'b1;
        s_start      = 1'b1;
        while (cyc < 20000 && !(cyc > 10 && s_busy === 1'b0 && fifo.size() == 0)) begin
            @(negedge CLK);
            acc = (s_byte_valid === 1'b1) && s_byte_ready;
            px  = (s_pix_ready === 1'b1) && s_pix_valid;
            b   = s_byte;
            if (s_line_done === 1'b1) dones++;
            @(posedge CLK);
            #1;
            s_start = 1'b0;
            if (acc) fifo.push_back(b);
            if ((cyc % 4) == 3 && fifo.size() > 0) ser.push_back(fifo.pop_front());
            if (px) begin
                k++;
                s_pix       = pixf(k);
                s_pix_valid = (k < 640);
            end
            s_byte_ready = (fifo.size() < 4);
            cyc++;
        end
        total++;
        if (ser.size() != 1285) begin
            bad++;
            $display("FAIL stream_len: got %0d want 1285", ser.size());
        end
        for (int i = 0; i < ser.size() && i < 1285; i++) begin
            total++;
            if (ser[i] !== expb[i]) begin
                bad++;
                $display("FAIL stream_byte[%0d]: got %h want %h", i, ser[i], expb[i]);
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL stream_line_done: got %0d pulses want 1", dones);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        RST          = 1'b0;
        i_start      = 1'b0;
        i_line       = '0;
        i_pix_valid  = 1'b0;
        i_pix        = '0;
        i_byte_ready = 1'b1;
        s_start      = 1'b0;
        s_line       = '0;
        s_pix_valid  = 1'b0;
        s_pix        = '0;
        s_byte_ready = 1'b1;
        pix_hold     = 1'b0;
        rand_bp      = 1'b0;
        done_exp     = 1'b0;
        hold_pend    = 1'b0;
        hold_byte    = '0;
        pxfer        = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_pixel_starve();
        test_start_while_busy();
        test_reset_mid_line();
        test_random_backpressure();
        test_uart_stream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
